dual_port_ram: RTL and testbench

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

---
 rtl/dual_port_ram.sv | 128 ++++++++++++
 tb/tb_dual_port_ram.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - true dual-port byte-enabled RAM with write arbitration and collision counter
// Optional macro DPRAM_OUTREG_EN adds one output register stage (read/ack latency 2 instead of 1).
module dual_port_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_ack,
    output logic                    a_err,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_ack,
    output logic                    b_err,
    output logic [CNT_WIDTH-1:0]    coll_cnt
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_wr, b_wr, same_addr, conflict, a_wins;
    logic                  a_wr_en, b_wr_en;
    logic [CNT_WIDTH-1:0]  coll_d;
    logic                  rr_q, rr_d;
    logic [CNT_WIDTH-1:0]  coll_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
    logic                  a_ack_q, b_ack_q, a_err_q, b_err_q;

    always_comb begin
        a_wr      = a_req & a_we;
        b_wr      = b_req & b_we;
        same_addr = (a_addr == b_addr);
        conflict  = a_wr & b_wr & same_addr;
        // rr_q=1 means B is owed the next conflict
        a_wins    = (ARB_MODE == 0) ? 1'b1 : ~rr_q;
        a_wr_en   = a_wr & (~conflict | a_wins);
        b_wr_en   = b_wr & (~conflict | ~a_wins);
        rr_d      = conflict ? a_wins : rr_q;
        coll_d    = coll_q;
        if (a_req && b_req && same_addr && (a_we || b_we) && (coll_q != {CNT_WIDTH{1'b1}})) begin
            coll_d = coll_q + CNT_WIDTH'(1);
        end
    end

    // Storage is deliberately left out of reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (a_wr_en && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            if (b_wr_en && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            rr_q      <= 1'b0;
            coll_q    <= '0;
        end else begin
            if (a_req && !a_we) a_rdata_q <= mem[a_addr];
            if (b_req && !b_we) b_rdata_q <= mem[b_addr];
            a_ack_q <= a_req;
            b_ack_q <= b_req;
            a_err_q <= a_wr & ~a_wr_en;
            b_err_q <= b_wr & ~b_wr_en;
            rr_q    <= rr_d;
            coll_q  <= coll_d;
        end
    end

    assign coll_cnt = coll_q;

`ifdef DPRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] a_rdata_o_q, b_rdata_o_q;
    logic                  a_ack_o_q, b_ack_o_q, a_err_o_q, b_err_o_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_o_q <= '0;
            b_rdata_o_q <= '0;
            a_ack_o_q   <= 1'b0;
            b_ack_o_q   <= 1'b0;
            a_err_o_q   <= 1'b0;
            b_err_o_q   <= 1'b0;
        end else begin
            a_rdata_o_q <= a_rdata_q;
            b_rdata_o_q <= b_rdata_q;
            a_ack_o_q   <= a_ack_q;
            b_ack_o_q   <= b_ack_q;
            a_err_o_q   <= a_err_q;
            b_err_o_q   <= b_err_q;
        end
    end

    assign a_rdata = a_rdata_o_q;
    assign b_rdata = b_rdata_o_q;
    assign a_ack   = a_ack_o_q;
    assign b_ack   = b_ack_o_q;
    assign a_err   = a_err_o_q;
    assign b_err   = b_err_o_q;
`else
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_err   = a_err_q;
    assign b_err   = b_err_q;
`endif

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - scoreboard bench for dual_port_ram (ARB_MODE=1, CNT_WIDTH=4)
module tb_dual_port_ram;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk, rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [3:0]    a_be, b_be;
    logic          a_ack, a_err, b_ack, b_err;
    logic [CW-1:0] coll_cnt;

    dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
        .coll_cnt(coll_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] m_mem [256];
    logic [31:0] m_held_a, m_held_b;
    logic        m_b_won_last;
    int          m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    exp_t ma, mb;
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ack) begin
                if (qa.size() == 0) check("a_unexpected_ack", 64'(a_ack), 64'(0));
                else begin
                    ma = qa.pop_front();
                    check("a_ack_cycle", 64'(cyc), 64'(ma.due));
                    check("a_rdata", 64'(a_rdata), 64'(ma.rdata));
                    check("a_err", 64'(a_err), 64'(ma.err));
                end
            end else if (qa.size() > 0 && cyc >= qa[0].due) begin
                ma = qa.pop_front();
                check("a_ack_missing", 64'(a_ack), 64'(1));
            end
            if (b_ack) begin
                if (qb.size() == 0) check("b_unexpected_ack", 64'(b_ack), 64'(0));
                else begin
                    mb = qb.pop_front();
                    check("b_ack_cycle", 64'(cyc), 64'(mb.due));
                    check("b_rdata", 64'(b_rdata), 64'(mb.rdata));
                    check("b_err", 64'(b_err), 64'(mb.err));
                end
            end else if (qb.size() > 0 && cyc >= qb[0].due) begin
                mb = qb.pop_front();
                check("b_ack_missing", 64'(b_ack), 64'(1));
            end
        end
    end

    // One request cycle: model the cycle's effect, queue expectations, then clock it in.
    task automatic step(input logic ar, input logic aw, input logic [7:0] aa, input logic [31:0] ad,
                        input logic [3:0] abe, input logic br, input logic bw, input logic [7:0] ba,
                        input logic [31:0] bd, input logic [3:0] bbe);
        exp_t ea, eb;
        logic a_w, b_w, clash, a_win;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; a_be = abe;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_be = bbe;
        a_w   = ar && aw;
        b_w   = br && bw;
        clash = a_w && b_w && (aa == ba);
        a_win = 1'b1;
        if (clash) begin
            a_win        = m_b_won_last;
            m_b_won_last = !a_win;
        end
        if (ar && br && aa == ba && (aw || bw) && m_cnt < CMAX) m_cnt++;
        if (ar) begin
            if (!aw) m_held_a = m_mem[aa];
            ea.rdata = m_held_a; ea.err = clash && !a_win; ea.due = cyc + LAT;
            qa.push_back(ea);
        end
        if (br) begin
            if (!bw) m_held_b = m_mem[ba];
            eb.rdata = m_held_b; eb.err = clash && a_win; eb.due = cyc + LAT;
            qb.push_back(eb);
        end
        if (a_w && !(clash && !a_win)) m_mem[aa] = merge(m_mem[aa], ad, abe);
        if (b_w && !(clash && a_win)) m_mem[ba] = merge(m_mem[ba], bd, bbe);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [7:0] ad, input logic [31:0] d, input logic [3:0] be);
        step(1'b1, 1'b1, ad, d, be, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask
    task automatic rd_a(input logic [7:0] ad);
        step(1'b1, 1'b0, ad, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    endtask
    task automatic rd_b(input logic [7:0] ad);
        step(1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b1, 1'b0, ad, 32'h0, 4'h0);
    endtask
    task automatic drain();
        repeat (LAT + 1) step(1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        check("drain_a", 64'(qa.size()), 64'(0));
        check("drain_b", 64'(qb.size()), 64'(0));
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
        qa.delete(); qb.delete();
        m_held_a = 0; m_held_b = 0; m_b_won_last = 1'b1; m_cnt = 0;
    endtask
    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        reset_assert();
        #1;
        check("rst_a_rdata", 64'(a_rdata), 64'(0));
        check("rst_b_rdata", 64'(b_rdata), 64'(0));
        check("rst_a_ack", 64'(a_ack), 64'(0));
        check("rst_b_ack", 64'(b_ack), 64'(0));
        check("rst_a_err", 64'(a_err), 64'(0));
        check("rst_b_err", 64'(b_err), 64'(0));
        check("rst_coll_cnt", 64'(coll_cnt), 64'(0));
        reset_release();

        for (int i = 0; i < 128; i++)
            step(1'b1, 1'b1, 8'(i), $urandom, 4'hF, 1'b1, 1'b1, 8'(i + 128), $urandom, 4'hF);
        drain();

        reset_assert();
        reset_release();

        // Round-robin conflicts right after reset: A, B, A win.
        step(1'b1, 1'b1, 8'h30, 32'd1, 4'hF, 1'b1, 1'b1, 8'h30, 32'd2, 4'hF);
        step(1'b1, 1'b1, 8'h30, 32'd3, 4'hF, 1'b1, 1'b1, 8'h30, 32'd4, 4'hF);
        step(1'b1, 1'b1, 8'h30, 32'd5, 4'hF, 1'b1, 1'b1, 8'h30, 32'd6, 4'hF);
        drain();
        check("rr_coll_cnt", 64'(coll_cnt), 64'(3));
        rd_a(8'h30);
        drain();
        check("rr_final_mem", 64'(a_rdata), 64'(5));

        wr_a(8'h10, 32'hDEADBEEF, 4'hF);
        rd_b(8'h10);
        drain();
        check("basic_b_rdata", 64'(b_rdata), 64'hDEADBEEF);

        wr_a(8'h20, 32'h11223344, 4'hF);
        wr_a(8'h20, 32'hAABBCCDD, 4'h5);
        rd_a(8'h20);
        drain();
        check("byte_en_rdata", 64'(a_rdata), 64'h11BB33DD);

        wr_a(8'h40, 32'd7, 4'hF);
        step(1'b1, 1'b1, 8'h40, 32'd9, 4'hF, 1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
        drain();
        check("rdw_old_data", 64'(b_rdata), 64'd7);
        check("rdw_coll_cnt", 64'(coll_cnt), 64'(4));
        rd_b(8'h40);
        drain();
        check("rdw_new_data", 64'(b_rdata), 64'd9);

        repeat (20) step(1'b1, 1'b1, 8'h50, $urandom, 4'hF, 1'b1, 1'b1, 8'h50, $urandom, 4'hF);
        drain();
        check("sat_coll_cnt", 64'(coll_cnt), 64'(CMAX));

        reset_assert();
        reset_release();
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 1'(($urandom)), 8'($urandom_range(0, 7)), $urandom, 4'($urandom),
                 ($urandom % 4) != 0, 1'(($urandom)), 8'($urandom_range(0, 7)), $urandom, 4'($urandom));
        drain();
        check("rand_coll_cnt", 64'(coll_cnt), 64'(m_cnt));

        rd_a(8'h10);
        reset_assert();
        #1;
        check("midrd_a_ack", 64'(a_ack), 64'(0));
        check("midrd_a_rdata", 64'(a_rdata), 64'(0));
        check("midrd_coll_cnt", 64'(coll_cnt), 64'(0));
        reset_release();
        drain();
        check("midrd_no_late_ack", 64'(a_ack), 64'(0));
        rd_b(8'h10);
        drain();
        check("retained_10", 64'(b_rdata), 64'hDEADBEEF);
        rd_a(8'h20);
        drain();
        check("retained_20", 64'(a_rdata), 64'h11BB33DD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
